// File: rtl/layer_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : layer_draw_arbiter
// Purpose  : Per-pixel compositor and collision scheduler. Each pixel, the
//            display path goes to the lowest-index requesting object layer,
//            or to the background when no layer requests. The result is
//            registered towards the VGA output. Collisions between the player
//            (layer 0) and the border / every other layer are reported once
//            per frame as pulses and as a per-frame snapshot.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   pixel clock
//   resetN          in   synchronous reset, active HIGH despite the name
//   startOfFrame    in   one-cycle pulse on the first pixel of a frame
//   pixelX/pixelY   in   current pixel coordinates (delayed only)
//   layerDrawReq    in   per-layer draw request
//   layerRGB        in   per-layer colour, layer i at [i*RGB_W +: RGB_W]
//   BG_RGB          in   background colour
//   boardersDrawReq in   border-bracket pixel indication
//   RGBOut          out  composited colour (registered)
//   layerSel        out  granted layer index, 4'hF = background (registered)
//   pixelXOut/YOut  out  coordinates aligned with RGBOut
//   collisionPulse  out  bit0 player/border, bit k player/layer k; pulses
//   frameCollisions out  collisions seen during the previous complete frame
//   frameCount      out  startOfFrame pulses since reset (wrapping)
// ============================================================================
module layer_draw_arbiter #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8,
  parameter int FCNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [10:0]                 pixelX,
  input  logic [10:0]                 pixelY,
  input  logic [NUM_LAYERS-1:0]       layerDrawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            BG_RGB,
  input  logic                        boardersDrawReq,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [3:0]                  layerSel,
  output logic [10:0]                 pixelXOut,
  output logic [10:0]                 pixelYOut,
  output logic [NUM_LAYERS-1:0]       collisionPulse,
  output logic [NUM_LAYERS-1:0]       frameCollisions,
  output logic [FCNT_W-1:0]           frameCount
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  localparam logic [3:0] SEL_BG = 4'hF;

  logic [0:0]            state_q, state_d;
  logic [RGB_W-1:0]      rgb_q, rgb_d;
  logic [3:0]            sel_q, sel_d;
  logic [10:0]           px_q, py_q;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] pulse_q, pulse_d;
  logic [NUM_LAYERS-1:0] fcoll_q, fcoll_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [NUM_LAYERS-1:0] coll;

  // Priority encode: scanning from the top index down lets the lowest
  // requesting index overwrite the result last, so it wins.
  always_comb begin
    sel_d = SEL_BG;
    rgb_d = BG_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerDrawReq[i]) begin
        sel_d = 4'(i);
        rgb_d = layerRGB[i*RGB_W +: RGB_W];
      end
    end
  end

  // Instantaneous collision vector; bit 0 is reused for the border because
  // the player cannot collide with itself.
  assign coll[0] = layerDrawReq[0] & boardersDrawReq;
  for (genvar k = 1; k < NUM_LAYERS; k++) begin : g_coll
    assign coll[k] = layerDrawReq[0] & layerDrawReq[k];
  end

  // Frame tracking. The boundary pixel belongs to the new frame, so its
  // collisions seed the accumulator and pulse unconditionally.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pulse_d = '0;
    fcoll_d = fcoll_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame) begin
          state_d = ST_IN_FRAME;
          fcnt_d  = FCNT_W'(1);
          acc_d   = coll;
          pulse_d = coll;
        end
      end
      ST_IN_FRAME: begin
        if (startOfFrame) begin
          fcoll_d = acc_q;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          acc_d   = coll;
          pulse_d = coll;
        end else begin
          pulse_d = coll & ~acc_q;
          acc_d   = acc_q | coll;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= ST_IDLE;
      rgb_q   <= '0;
      sel_q   <= SEL_BG;
      px_q    <= '0;
      py_q    <= '0;
      acc_q   <= '0;
      pulse_q <= '0;
      fcoll_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      sel_q   <= sel_d;
      px_q    <= pixelX;
      py_q    <= pixelY;
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
      fcoll_q <= fcoll_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign RGBOut          = rgb_q;
  assign layerSel        = sel_q;
  assign pixelXOut       = px_q;
  assign pixelYOut       = py_q;
  assign collisionPulse  = pulse_q;
  assign frameCollisions = fcoll_q;
  assign frameCount      = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_draw_arbiter
// Purpose  : Self-checking bench for layer_draw_arbiter. A behavioural model
//            (first-requester grant, per-frame "seen" set) predicts every
//            registered output. A second instance with a 4-bit frame counter
//            exercises counter wrap-around in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_draw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof;
  logic [10:0] px, py;
  logic [3:0]  req;
  logic [31:0] lrgb;
  logic [7:0]  bg;
  logic        bord;

  logic [7:0]  rgb_o;
  logic [3:0]  sel_o;
  logic [10:0] pxo, pyo;
  logic [3:0]  pulse_o, fcoll_o;
  logic [15:0] fc_o;

  logic [7:0]  s_rgb;
  logic [3:0]  s_sel;
  logic [10:0] s_pxo, s_pyo;
  logic [3:0]  s_pulse, s_fcoll;
  logic [3:0]  s_fc;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_in;
  logic [3:0] m_acc, m_fcoll, m_pulse, m_sel;
  logic [7:0] m_rgb;
  logic [10:0] m_px, m_py;
  int         m_fc;

  always #5 clk = ~clk;

  layer_draw_arbiter #(.NUM_LAYERS(4), .RGB_W(8), .FCNT_W(16)) dut (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .layerDrawReq(req), .layerRGB(lrgb), .BG_RGB(bg), .boardersDrawReq(bord),
    .RGBOut(rgb_o), .layerSel(sel_o), .pixelXOut(pxo), .pixelYOut(pyo),
    .collisionPulse(pulse_o), .frameCollisions(fcoll_o), .frameCount(fc_o)
  );

  layer_draw_arbiter #(.NUM_LAYERS(4), .RGB_W(8), .FCNT_W(4)) dut_small (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .layerDrawReq(req), .layerRGB(lrgb), .BG_RGB(bg), .boardersDrawReq(bord),
    .RGBOut(s_rgb), .layerSel(s_sel), .pixelXOut(s_pxo), .pixelYOut(s_pyo),
    .collisionPulse(s_pulse), .frameCollisions(s_fcoll), .frameCount(s_fc)
  );

  // Advance the model with the current inputs, then clock and settle.
  task automatic tick();
    logic [3:0] coll;
    int g;
    if (rst) begin
      m_in = 0; m_acc = '0; m_fcoll = '0; m_pulse = '0; m_fc = 0;
      m_rgb = '0; m_sel = 4'hF; m_px = '0; m_py = '0;
    end else begin
      g = -1;
      for (int i = 0; i < 4; i++) if (req[i] && g < 0) g = i;
      if (g >= 0) begin m_rgb = lrgb[g*8 +: 8]; m_sel = g[3:0]; end
      else begin m_rgb = bg; m_sel = 4'hF; end
      m_px = px; m_py = py;
      for (int k = 0; k < 4; k++) coll[k] = req[0] && ((k == 0) ? bord : req[k]);
      if (sof) begin
        if (m_in) m_fcoll = m_acc;
        m_fc    = m_in ? (m_fc + 1) % 65536 : 1;
        m_acc   = coll;
        m_pulse = coll;
        m_in    = 1;
      end else if (m_in) begin
        for (int k = 0; k < 4; k++) m_pulse[k] = coll[k] && !m_acc[k];
        m_acc = m_acc | coll;
      end else begin
        m_pulse = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sof = 0; req = 4'b1111; lrgb = 32'h44332211; bg = 8'h55;
    bord = 1; px = 11'd7; py = 11'd9;
    repeat (3) tick();
    n_tests++; if (rgb_o !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h exp 00", rgb_o); end
    n_tests++; if (sel_o !== 4'hF) begin n_fail++; $display("FAIL reset_sel got %h exp F", sel_o); end
    n_tests++; if (pxo !== 11'd0 || pyo !== 11'd0) begin n_fail++; $display("FAIL reset_xy got %0d,%0d exp 0,0", pxo, pyo); end
    n_tests++; if (pulse_o !== 4'd0 || fcoll_o !== 4'd0 || fc_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_coll got p=%b f=%b c=%0d exp 0", pulse_o, fcoll_o, fc_o); end
    rst = 0;
    tick();
    n_tests++; if (rgb_o !== 8'h11) begin n_fail++; $display("FAIL post_reset_rgb got %h exp 11", rgb_o); end
    n_tests++; if (pulse_o !== 4'd0) begin n_fail++; $display("FAIL post_reset_pulse got %b exp 0000", pulse_o); end
    n_tests++; if (pxo !== 11'd7 || pyo !== 11'd9) begin n_fail++; $display("FAIL post_reset_xy got %0d,%0d exp 7,9", pxo, pyo); end
  endtask

  task automatic test_grant();
    bord = 0; req = 4'b0110; lrgb = 32'h001CE000;
    tick();
    n_tests++; if (rgb_o !== 8'hE0 || sel_o !== 4'd1) begin
      n_fail++; $display("FAIL grant_l1 got rgb=%h sel=%h exp E0/1", rgb_o, sel_o); end
    req = 4'b0000; bg = 8'hE4;
    tick();
    n_tests++; if (rgb_o !== 8'hE4 || sel_o !== 4'hF) begin
      n_fail++; $display("FAIL grant_bg got rgb=%h sel=%h exp E4/F", rgb_o, sel_o); end
  endtask

  task automatic test_single_pulse();
    logic [3:0] exp_p;
    sof = 1; req = 4'b0000; bord = 0;
    tick();
    n_tests++; if (fc_o !== 16'd1) begin n_fail++; $display("FAIL first_frame_count got %0d exp 1", fc_o); end
    sof = 0; req = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_p = (i == 0) ? 4'b0100 : 4'b0000;
      n_tests++; if (pulse_o !== exp_p) begin n_fail++; $display("FAIL single_pulse[%0d] got %b exp %b", i, pulse_o, exp_p); end
    end
    req = 4'b0000; sof = 1;
    tick();
    n_tests++; if (fcoll_o !== 4'b0100) begin n_fail++; $display("FAIL frame_coll got %b exp 0100", fcoll_o); end
    n_tests++; if (fc_o !== 16'd2) begin n_fail++; $display("FAIL frame_count got %0d exp 2", fc_o); end
    sof = 0;
  endtask

  task automatic test_border_boundary();
    repeat (3) tick();
    sof = 1; req = 4'b0001; bord = 1;
    tick();
    n_tests++; if (pulse_o !== 4'b0001) begin n_fail++; $display("FAIL border_pulse got %b exp 0001", pulse_o); end
    n_tests++; if (fcoll_o !== 4'b0000) begin n_fail++; $display("FAIL border_old_frame got %b exp 0000", fcoll_o); end
    sof = 0; req = 4'b0000; bord = 0;
    repeat (3) tick();
    sof = 1;
    tick();
    n_tests++; if (fcoll_o !== 4'b0001) begin n_fail++; $display("FAIL border_new_frame got %b exp 0001", fcoll_o); end
    sof = 0;
  endtask

  task automatic test_span();
    int cnt;
    cnt = 0;
    req = 4'b1001;
    tick();
    n_tests++; if (pulse_o !== 4'b1000) begin n_fail++; $display("FAIL span_first got %b exp 1000", pulse_o); end
    cnt += pulse_o[3];
    repeat (5) begin tick(); cnt += pulse_o[3]; end
    sof = 1;
    tick();
    n_tests++; if (pulse_o !== 4'b1000) begin n_fail++; $display("FAIL span_second got %b exp 1000", pulse_o); end
    cnt += pulse_o[3];
    sof = 0;
    repeat (5) begin tick(); cnt += pulse_o[3]; end
    n_tests++; if (cnt != 2) begin n_fail++; $display("FAIL span_count got %0d exp 2", cnt); end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    sof = 1;
    while ((m_fc % 16) != 15 && guard < 40) begin tick(); guard++; end
    n_tests++; if (s_fc !== 4'hF) begin n_fail++; $display("FAIL wrap_pre got %h exp F", s_fc); end
    tick();
    n_tests++; if (s_fc !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp 0", s_fc); end
    n_tests++; if (fc_o !== 16'(m_fc)) begin n_fail++; $display("FAIL wrap_wide got %0d exp %0d", fc_o, m_fc); end
    sof = 0;
  endtask

  task automatic test_reset_mid();
    sof = 1; req = 4'b0000;
    tick();
    sof = 0; req = 4'b0101;
    tick();
    rst = 1;
    tick();
    n_tests++; if (fcoll_o !== 4'd0 || pulse_o !== 4'd0 || fc_o !== 16'd0) begin
      n_fail++; $display("FAIL midreset got f=%b p=%b c=%0d exp 0", fcoll_o, pulse_o, fc_o); end
    rst = 0;
    repeat (3) begin
      tick();
      n_tests++; if (pulse_o !== 4'd0) begin n_fail++; $display("FAIL idle_pulse got %b exp 0000", pulse_o); end
    end
    sof = 1; req = 4'b0000;
    tick();
    n_tests++; if (fcoll_o !== 4'd0 || pulse_o !== 4'd0 || fc_o !== 16'd1) begin
      n_fail++; $display("FAIL after_reset_sof got f=%b p=%b c=%0d exp 0/0/1", fcoll_o, pulse_o, fc_o); end
    sof = 0; req = 4'b0101;
    tick();
    n_tests++; if (pulse_o !== 4'b0100) begin n_fail++; $display("FAIL after_reset_coll got %b exp 0100", pulse_o); end
    req = 4'b0000;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      sof  = ($urandom_range(0, 24) == 0);
      req  = 4'($urandom) & 4'($urandom);
      lrgb = $urandom;
      bg   = 8'($urandom);
      bord = 1'($urandom);
      px   = 11'($urandom);
      py   = 11'($urandom);
      tick();
      n_tests++; if (rgb_o !== m_rgb || sel_o !== m_sel) begin
        n_fail++; $display("FAIL rnd_grant[%0d] got %h/%h exp %h/%h", n, rgb_o, sel_o, m_rgb, m_sel); end
      n_tests++; if (pxo !== m_px || pyo !== m_py) begin
        n_fail++; $display("FAIL rnd_xy[%0d] got %0d,%0d exp %0d,%0d", n, pxo, pyo, m_px, m_py); end
      n_tests++; if (pulse_o !== m_pulse) begin
        n_fail++; $display("FAIL rnd_pulse[%0d] got %b exp %b", n, pulse_o, m_pulse); end
      n_tests++; if (fcoll_o !== m_fcoll) begin
        n_fail++; $display("FAIL rnd_fcoll[%0d] got %b exp %b", n, fcoll_o, m_fcoll); end
      n_tests++; if (fc_o !== 16'(m_fc) || s_fc !== 4'(m_fc % 16)) begin
        n_fail++; $display("FAIL rnd_fcount[%0d] got %0d/%0d exp %0d", n, fc_o, s_fc, m_fc); end
    end
    rst = 0; sof = 0;
  endtask

  initial begin
    test_reset();
    test_grant();
    test_single_pulse();
    test_border_boundary();
    test_span();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
